rd_txn_guard: RTL

Parametrised multi-outstanding AXI read-path watchdog inserted between a read manager (upstream, `s_`) and subordinate (downstream, `m_`). It tracks up to `MaxTxns` in-flight reads in a slot table with per-ID ordering and three programmable latency budgets per transaction. Timeouts and unexpected responses raise a sticky interrupt and gate new AR requests. Only AR/R handshake, ID and last signals pass through the block; AR/R payload is routed externally.

---
 rtl/rd_txn_guard.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/rd_txn_guard.sv
// AXI read-path watchdog: tracks in-flight reads in a slot table, enforces three
// latency budgets per transaction and flags unexpected R IDs with a sticky fault.
module rd_txn_guard #(
    parameter int IdWidth      = 4,
    parameter int MaxTxns      = 8,
    parameter int LatencyWidth = 10
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           guard_en_i,
    input  logic                           irq_clear_i,
    input  logic                           s_ar_valid_i,
    output logic                           s_ar_ready_o,
    input  logic [IdWidth-1:0]             s_ar_id_i,
    output logic                           m_ar_valid_o,
    input  logic                           m_ar_ready_i,
    input  logic                           r_valid_i,
    input  logic                           r_ready_i,
    input  logic                           r_last_i,
    input  logic [IdWidth-1:0]             r_id_i,
    input  logic [LatencyWidth-1:0]        budget_ar_i,
    input  logic [LatencyWidth-1:0]        budget_first_i,
    input  logic [LatencyWidth-1:0]        budget_last_i,
    output logic                           irq_o,
    output logic [2:0]                     fault_code_o,
    output logic [IdWidth-1:0]             fault_id_o,
    output logic [$clog2(MaxTxns+1)-1:0]   outstanding_o
);
    localparam int CntW = $clog2(MaxTxns + 1);
    localparam int IdxW = $clog2(MaxTxns);

    typedef enum logic [1:0] {
        SlotFree   = 2'd0,
        SlotArWait = 2'd1,
        SlotRFirst = 2'd2,
        SlotRBurst = 2'd3
    } slot_state_e;

    slot_state_e             state_q [MaxTxns];
    slot_state_e             state_d [MaxTxns];
    logic [IdWidth-1:0]      id_q    [MaxTxns];
    logic [IdWidth-1:0]      id_d    [MaxTxns];
    logic [IdxW-1:0]         order_q [MaxTxns];
    logic [IdxW-1:0]         order_d [MaxTxns];
    logic [LatencyWidth-1:0] cnt_q   [MaxTxns];
    logic [LatencyWidth-1:0] cnt_d   [MaxTxns];

    logic               fault_q, fault_d;
    logic [2:0]         code_q, code_d;
    logic [IdWidth-1:0] fid_q, fid_d;
    logic [CntW-1:0]    outstanding_q, outstanding_d;

    logic [MaxTxns-1:0] busy, match, timeout, free_now;
    logic               ar_wait_any, table_full, alloc_ok, alloc_found;
    logic               ar_hs, r_hs, match_any;
    logic [IdxW-1:0]    alloc_idx, alloc_order, dec;
    logic               new_fault;
    logic [2:0]         new_code;
    logic [IdWidth-1:0] new_id;

    assign r_hs      = guard_en_i & r_valid_i & r_ready_i;
    assign match_any = |match;

    for (genvar gi = 0; gi < MaxTxns; gi++) begin : g_slot
        logic [LatencyWidth-1:0] budget;
        always_comb begin
            budget = '0;
            case (state_q[gi])
                SlotArWait: budget = budget_ar_i;
                SlotRFirst: budget = budget_first_i;
                SlotRBurst: budget = budget_last_i;
                default:    budget = '0;
            endcase
        end
        assign busy[gi]    = (state_q[gi] != SlotFree);
        // Only the oldest same-ID read (order 0) may accept an R beat.
        assign match[gi]   = r_hs && (state_q[gi] == SlotRFirst || state_q[gi] == SlotRBurst)
                             && (id_q[gi] == r_id_i) && (order_q[gi] == '0);
        assign timeout[gi] = guard_en_i && busy[gi] && (budget != '0) && (cnt_q[gi] >= budget);
        assign free_now[gi] = busy[gi] && ((timeout[gi] && state_q[gi] != SlotArWait)
                              || (match[gi] && r_last_i));
    end

    assign table_full = &busy;

    always_comb begin
        ar_wait_any = 1'b0;
        alloc_found = 1'b0;
        alloc_idx   = '0;
        alloc_order = '0;
        for (int i = 0; i < MaxTxns; i++) begin
            if (state_q[i] == SlotArWait) ar_wait_any = 1'b1;
            if (!busy[i] && !alloc_found) begin
                alloc_found = 1'b1;
                alloc_idx   = IdxW'(i);
            end
            if (busy[i] && !free_now[i] && id_q[i] == s_ar_id_i) alloc_order = alloc_order + IdxW'(1);
        end
    end

    always_comb begin
        alloc_ok     = guard_en_i & s_ar_valid_i & ~ar_wait_any & ~table_full & ~fault_q;
        m_ar_valid_o = guard_en_i ? (s_ar_valid_i & (ar_wait_any | alloc_ok)) : s_ar_valid_i;
        s_ar_ready_o = guard_en_i ? (m_ar_ready_i & m_ar_valid_o) : m_ar_ready_i;
        ar_hs        = guard_en_i & s_ar_valid_i & m_ar_valid_o & m_ar_ready_i;
    end

    // Descending scan so the lowest slot wins; an unexpected R ID overrides all.
    always_comb begin
        new_fault = 1'b0;
        new_code  = 3'd0;
        new_id    = '0;
        for (int i = MaxTxns - 1; i >= 0; i--) begin
            if (timeout[i]) begin
                new_fault = 1'b1;
                new_code  = (state_q[i] == SlotArWait) ? 3'd1 :
                            (state_q[i] == SlotRFirst) ? 3'd2 : 3'd3;
                new_id    = id_q[i];
            end
        end
        if (r_hs && !match_any) begin
            new_fault = 1'b1;
            new_code  = 3'd4;
            new_id    = r_id_i;
        end
    end

    always_comb begin
        fault_d = fault_q;
        code_d  = code_q;
        fid_d   = fid_q;
        if (guard_en_i) begin
            if (new_fault && (!fault_q || irq_clear_i)) begin
                fault_d = 1'b1;
                code_d  = new_code;
                fid_d   = new_id;
            end else if (irq_clear_i) begin
                fault_d = 1'b0;
                code_d  = 3'd0;
                fid_d   = '0;
            end
        end
    end

    always_comb begin
        dec = '0;
        for (int i = 0; i < MaxTxns; i++) begin
            state_d[i] = state_q[i];
            id_d[i]    = id_q[i];
            order_d[i] = order_q[i];
            cnt_d[i]   = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + LatencyWidth'(1);
            // Older same-ID reads leaving this cycle move this one up the queue.
            dec = '0;
            for (int j = 0; j < MaxTxns; j++) begin
                if (free_now[j] && id_q[j] == id_q[i] && order_q[j] < order_q[i])
                    dec = dec + IdxW'(1);
            end
            case (state_q[i])
                SlotFree: begin
                    cnt_d[i]   = '0;
                    order_d[i] = '0;
                    if (alloc_ok && alloc_idx == IdxW'(i)) begin
                        id_d[i]    = s_ar_id_i;
                        order_d[i] = alloc_order;
                        state_d[i] = ar_hs ? SlotRFirst : SlotArWait;
                    end
                end
                SlotArWait: begin
                    order_d[i] = order_q[i] - dec;
                    if (ar_hs) begin
                        state_d[i] = SlotRFirst;
                        cnt_d[i]   = '0;
                    end
                end
                default: begin
                    if (free_now[i]) begin
                        state_d[i] = SlotFree;
                        cnt_d[i]   = '0;
                        order_d[i] = '0;
                    end else begin
                        order_d[i] = order_q[i] - dec;
                        if (match[i] && !r_last_i && state_q[i] == SlotRFirst) begin
                            state_d[i] = SlotRBurst;
                            cnt_d[i]   = '0;
                        end
                    end
                end
            endcase
            if (!guard_en_i) begin
                state_d[i] = SlotFree;
                cnt_d[i]   = '0;
                order_d[i] = '0;
            end
        end
    end

    always_comb begin
        outstanding_d = '0;
        for (int i = 0; i < MaxTxns; i++) begin
            if (state_d[i] != SlotFree) outstanding_d = outstanding_d + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MaxTxns; i++) begin
                state_q[i] <= SlotFree;
                id_q[i]    <= '0;
                order_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
            fault_q       <= 1'b0;
            code_q        <= 3'd0;
            fid_q         <= '0;
            outstanding_q <= '0;
        end else begin
            for (int i = 0; i < MaxTxns; i++) begin
                state_q[i] <= state_d[i];
                id_q[i]    <= id_d[i];
                order_q[i] <= order_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            fault_q       <= fault_d;
            code_q        <= code_d;
            fid_q         <= fid_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign irq_o         = fault_q;
    assign fault_code_o  = code_q;
    assign fault_id_o    = fid_q;
    assign outstanding_o = outstanding_q;

endmodule
